// File: rtl/neg_pipe.sv
// neg_pipe: two-stage pass/negate/abs unit, 2-cycle latency, 1 beat/cycle; per-stage ready, bubbles collapse.
// Define NEG_PIPE_SAT_EN to saturate overflowed results to the most-positive value instead of wrapping.
module neg_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic             cnt_clr
);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // S1: operand already conditionally inverted, plus the +1 still owed
   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_val_q, s1_val_d;
   logic             s1_neg_q, s1_neg_d;
   logic             s1_ovf_q, s1_ovf_d;

   logic             s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0] s2_dat_q, s2_dat_d;
   logic             s2_ovf_q, s2_ovf_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             in_neg;
   logic             s1_rdy;
   logic             s2_rdy;
   logic [WIDTH-1:0] s2_sum;
   logic [WIDTH-1:0] s2_res;
   logic             out_xfer;

   always_comb begin
      in_neg = 1'b0;
      case (mode_e'(in_mode))
         MODE_NEG: in_neg = 1'b1;
         MODE_ABS: in_neg = in_data[WIDTH-1];
         default:  in_neg = 1'b0;
      endcase
   end

   assign s2_rdy   = ~s2_vld_q | out_ready;
   assign s1_rdy   = ~s1_vld_q | s2_rdy;
   assign in_ready = s1_rdy;
   assign out_xfer = s2_vld_q & out_ready;

   assign s2_sum = s1_val_q + WIDTH'(s1_neg_q);
`ifdef NEG_PIPE_SAT_EN
   assign s2_res = s1_ovf_q ? ~MOST_NEG : s2_sum;
`else
   assign s2_res = s2_sum;
`endif

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_val_d = s1_val_q;
      s1_neg_d = s1_neg_q;
      s1_ovf_d = s1_ovf_q;
      if (s1_rdy) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_val_d = in_neg ? ~in_data : in_data;
            s1_neg_d = in_neg;
            s1_ovf_d = in_neg && (in_data == MOST_NEG);
         end
      end
   end

   always_comb begin
      s2_vld_d = s2_vld_q;
      s2_dat_d = s2_dat_q;
      s2_ovf_d = s2_ovf_q;
      if (s2_rdy) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_dat_d = s2_res;
            s2_ovf_d = s1_ovf_q;
         end
      end
   end

   // Clear wins over a coincident overflow transfer
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (out_xfer && s2_ovf_q && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_val_q <= '0;
         s1_neg_q <= 1'b0;
         s1_ovf_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s2_dat_q <= '0;
         s2_ovf_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_val_q <= s1_val_d;
         s1_neg_q <= s1_neg_d;
         s1_ovf_q <= s1_ovf_d;
         s2_vld_q <= s2_vld_d;
         s2_dat_q <= s2_dat_d;
         s2_ovf_q <= s2_ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = s2_vld_q;
   assign out_data  = s2_dat_q;
   assign out_ovf   = s2_ovf_q;
   assign ovf_cnt   = cnt_q;

endmodule
